// File: rtl/pss_tracker_if.sv
// rtl/pss_tracker_if.sv - Detector-facing bundle between the PSS detector and the tracker.
interface pss_tracker_if;
  logic        enable_i;
  logic        s_axis_in_tvalid;
  logic [1:0]  N_id_2_i;
  logic        N_id_2_valid_i;
  logic [1:0]  mode_o;
  logic [1:0]  requested_N_id_2_o;
  logic [1:0]  N_id_2_o;
  logic        lock_o;
  logic        ssb_start_o;
  logic [15:0] timing_err_o;
  logic        timing_err_valid_o;
  logic        missed_o;

  modport master (
    output enable_i, s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
    input  mode_o, requested_N_id_2_o, N_id_2_o, lock_o, ssb_start_o,
           timing_err_o, timing_err_valid_o, missed_o
  );

  modport slave (
    input  enable_i, s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
    output mode_o, requested_N_id_2_o, N_id_2_o, lock_o, ssb_start_o,
           timing_err_o, timing_err_valid_o, missed_o
  );
endinterface

// File: rtl/pss_tracker.sv
// rtl/pss_tracker.sv - SSB timing tracker: search/pause/find loop around the PSS detector.
module pss_tracker #(
  parameter int SSB_INTERVAL    = 38400,
  parameter int TRACK_TOLERANCE = 100,
  parameter int LOCK_HITS       = 2,
  parameter int MAX_MISSES      = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  pss_tracker_if.slave  bus
);
  localparam int CNT_W  = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1);
  localparam int HIT_W  = $clog2(LOCK_HITS + 1);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  localparam logic [CNT_W-1:0]  PAUSE_END = CNT_W'(SSB_INTERVAL - TRACK_TOLERANCE - 1);
  localparam logic [CNT_W-1:0]  FIND_END  = CNT_W'(SSB_INTERVAL + TRACK_TOLERANCE);
  localparam logic [CNT_W-1:0]  FLYWHEEL  = CNT_W'(TRACK_TOLERANCE + 1);
  localparam logic [HIT_W-1:0]  HITS_MAX  = HIT_W'(LOCK_HITS);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MAX_MISSES);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_PAUSE, S_FIND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HIT_W-1:0]    hits_q, hits_d, hits_inc;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic                lock_q, lock_d;
  logic [1:0]          nid_q, nid_d, req_q, req_d, mode_q, mode_d;
  logic                ssb_q, ssb_d, missed_q, missed_d;
  logic [15:0]         err_q, err_d;
  logic [31:0]         err_full;
  logic                hit, expire;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd2;
      cnt_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      lock_q   <= 1'b0;
      nid_q    <= 2'd0;
      req_q    <= 2'd0;
      ssb_q    <= 1'b0;
      missed_q <= 1'b0;
      err_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      lock_q   <= lock_d;
      nid_q    <= nid_d;
      req_q    <= req_d;
      ssb_q    <= ssb_d;
      missed_q <= missed_d;
      err_q    <= err_d;
    end
  end

  // A hit outranks expiry on the same sample, so expire is qualified by !hit.
  assign hit      = (state_q == S_FIND) && bus.N_id_2_valid_i && (bus.N_id_2_i == req_q);
  assign expire   = (state_q == S_FIND) && bus.s_axis_in_tvalid && (cnt_q == FIND_END) && !hit;
  assign hits_inc = (hits_q == HITS_MAX) ? hits_q : hits_q + HIT_W'(1);
  assign err_full = 32'(cnt_q) - 32'(SSB_INTERVAL);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    lock_d   = lock_q;
    nid_d    = nid_q;
    req_d    = req_q;
    ssb_d    = 1'b0;
    missed_d = 1'b0;
    err_d    = err_q;
    if (!bus.enable_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      hits_d   = '0;
      misses_d = '0;
      lock_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_SEARCH;
        S_SEARCH: begin
          if (bus.N_id_2_valid_i) begin
            nid_d    = bus.N_id_2_i;
            req_d    = bus.N_id_2_i;
            ssb_d    = 1'b1;
            err_d    = 16'd0;
            hits_d   = HIT_W'(1);
            misses_d = '0;
            cnt_d    = '0;
            lock_d   = (LOCK_HITS == 1);
            state_d  = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (bus.s_axis_in_tvalid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == PAUSE_END) state_d = S_FIND;
          end
        end
        S_FIND: begin
          if (hit) begin
            err_d    = err_full[15:0];
            ssb_d    = 1'b1;
            cnt_d    = '0;
            misses_d = '0;
            hits_d   = hits_inc;
            lock_d   = lock_q | (hits_inc == HITS_MAX);
            state_d  = S_PAUSE;
          end else if (expire) begin
            missed_d = 1'b1;
            hits_d   = '0;
            if (misses_q >= MISS_MAX - MISS_W'(1)) begin
              misses_d = MISS_MAX;
              lock_d   = 1'b0;
              cnt_d    = '0;
              state_d  = S_SEARCH;
            end else begin
              // Re-centre on the nominal SSB position so the next window stays aligned.
              misses_d = misses_q + MISS_W'(1);
              cnt_d    = FLYWHEEL;
              state_d  = S_PAUSE;
            end
          end else if (bus.s_axis_in_tvalid && cnt_q != FIND_END) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d = 2'd2;
    case (state_d)
      S_SEARCH: mode_d = 2'd0;
      S_FIND:   mode_d = 2'd1;
      default:  mode_d = 2'd2;
    endcase
  end

  assign bus.mode_o             = mode_q;
  assign bus.requested_N_id_2_o = req_q;
  assign bus.N_id_2_o           = nid_q;
  assign bus.lock_o             = lock_q;
  assign bus.ssb_start_o        = ssb_q;
  assign bus.timing_err_o       = err_q;
  assign bus.timing_err_valid_o = ssb_q;
  assign bus.missed_o           = missed_q;
endmodule

// File: tb/tb_pss_tracker.sv
// tb/tb_pss_tracker.sv - Directed bench for pss_tracker with a 1000-sample SSB period.
module tb_pss_tracker;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pss_tracker_if bus();

  pss_tracker #(
    .SSB_INTERVAL(1000), .TRACK_TOLERANCE(10), .LOCK_HITS(2), .MAX_MISSES(2)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic detect(input logic [1:0] id);
    bus.N_id_2_i       = id;
    bus.N_id_2_valid_i = 1'b1;
    step(1);
    bus.N_id_2_valid_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus.enable_i         = 1'b1;
    bus.s_axis_in_tvalid = 1'b1;
    bus.N_id_2_i         = 2'd0;
    bus.N_id_2_valid_i   = 1'b0;
    step(2);
    chk("rst_mode",  32'(bus.mode_o), 32'd2);
    chk("rst_lock",  32'(bus.lock_o), 32'd0);
    chk("rst_nid",   32'(bus.N_id_2_o), 32'd0);
    chk("rst_req",   32'(bus.requested_N_id_2_o), 32'd0);
    chk("rst_ssb",   32'(bus.ssb_start_o), 32'd0);
    chk("rst_err",   32'(bus.timing_err_o), 32'd0);
    chk("rst_miss",  32'(bus.missed_o), 32'd0);

    rst = 1'b0;
    step(1);
    chk("search_mode", 32'(bus.mode_o), 32'd0);
    detect(2'd1);
    chk("s_ssb",  32'(bus.ssb_start_o), 32'd1);
    chk("s_tev",  32'(bus.timing_err_valid_o), 32'd1);
    chk("s_err",  32'(bus.timing_err_o), 32'd0);
    chk("s_nid",  32'(bus.N_id_2_o), 32'd1);
    chk("s_req",  32'(bus.requested_N_id_2_o), 32'd1);
    chk("s_mode", 32'(bus.mode_o), 32'd2);
    chk("s_lock", 32'(bus.lock_o), 32'd0);

    step(989);
    chk("pause_989", 32'(bus.mode_o), 32'd2);
    step(1);
    chk("find_990", 32'(bus.mode_o), 32'd1);

    step(13);
    detect(2'd1);
    chk("hit1_ssb",  32'(bus.ssb_start_o), 32'd1);
    chk("hit1_err",  32'(bus.timing_err_o), 32'h0003);
    chk("hit1_lock", 32'(bus.lock_o), 32'd1);

    step(997);
    detect(2'd1);
    chk("hit2_ssb",  32'(bus.ssb_start_o), 32'd1);
    chk("hit2_err",  32'(bus.timing_err_o), 32'hFFFD);
    chk("hit2_lock", 32'(bus.lock_o), 32'd1);
    step(1);
    chk("hit2_pulse_end", 32'(bus.ssb_start_o), 32'd0);

    step(1009);
    chk("miss1_pre",  32'(bus.missed_o), 32'd0);
    chk("miss1_pre_mode", 32'(bus.mode_o), 32'd1);
    step(1);
    chk("miss1",      32'(bus.missed_o), 32'd1);
    chk("miss1_mode", 32'(bus.mode_o), 32'd2);
    chk("miss1_lock", 32'(bus.lock_o), 32'd1);
    step(999);
    chk("miss2_pre",  32'(bus.missed_o), 32'd0);
    step(1);
    chk("miss2",      32'(bus.missed_o), 32'd1);
    chk("miss2_lock", 32'(bus.lock_o), 32'd0);
    chk("miss2_mode", 32'(bus.mode_o), 32'd0);

    detect(2'd2);
    chk("re_ssb",  32'(bus.ssb_start_o), 32'd1);
    chk("re_nid",  32'(bus.N_id_2_o), 32'd2);
    chk("re_lock", 32'(bus.lock_o), 32'd0);
    step(500);
    detect(2'd2);
    chk("pause_det_ignored", 32'(bus.ssb_start_o), 32'd0);
    step(489);
    chk("re_find", 32'(bus.mode_o), 32'd1);
    detect(2'd0);
    chk("wrong_id_ignored", 32'(bus.ssb_start_o), 32'd0);
    step(4);
    detect(2'd2);
    chk("right_id_ssb",  32'(bus.ssb_start_o), 32'd1);
    chk("right_id_err",  32'(bus.timing_err_o), 32'hFFFB);
    chk("right_id_lock", 32'(bus.lock_o), 32'd1);

    step(1010);
    chk("edge_mode", 32'(bus.mode_o), 32'd1);
    detect(2'd2);
    chk("edge_ssb",  32'(bus.ssb_start_o), 32'd1);
    chk("edge_err",  32'(bus.timing_err_o), 32'h000A);
    chk("edge_miss", 32'(bus.missed_o), 32'd0);
    chk("edge_mode_after", 32'(bus.mode_o), 32'd2);

    step(995);
    chk("en_find", 32'(bus.mode_o), 32'd1);
    bus.enable_i = 1'b0;
    step(1);
    chk("dis_mode", 32'(bus.mode_o), 32'd2);
    chk("dis_lock", 32'(bus.lock_o), 32'd0);
    chk("dis_nid",  32'(bus.N_id_2_o), 32'd2);
    bus.enable_i = 1'b1;
    step(1);
    chk("reen_mode", 32'(bus.mode_o), 32'd0);

    detect(2'd3);
    chk("d3_nid", 32'(bus.N_id_2_o), 32'd3);
    step(1000);
    detect(2'd3);
    chk("d3_err",  32'(bus.timing_err_o), 32'd0);
    chk("d3_lock", 32'(bus.lock_o), 32'd1);
    step(995);
    chk("r_find", 32'(bus.mode_o), 32'd1);
    rst = 1'b1;
    step(1);
    chk("midrst_mode", 32'(bus.mode_o), 32'd2);
    chk("midrst_lock", 32'(bus.lock_o), 32'd0);
    chk("midrst_nid",  32'(bus.N_id_2_o), 32'd0);

    rst = 1'b0;
    step(1);
    detect(2'd1);
    bus.s_axis_in_tvalid = 1'b0;
    step(2000);
    chk("stall_mode", 32'(bus.mode_o), 32'd2);
    bus.s_axis_in_tvalid = 1'b1;
    step(989);
    chk("stall_pause", 32'(bus.mode_o), 32'd2);
    step(1);
    chk("stall_find", 32'(bus.mode_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
